// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter/sequencer for the shared two-input datapath mux, bounded bursts per grant.
// Latency: grant visible 1 cycle after req first seen in IDLE; re-grant on release has no bubble.
// Backpressure: out_ready low stalls the owner indefinitely; beats count only on out_valid && out_ready.
module mux_share_arbiter #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel_mux,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t     state;
  logic       owner;
  logic       last;
  logic [3:0] cnt;

  logic owner_req;
  logic any_req;
  logic beat;
  logic burst_done;
  logic release_now;
  logic pick_idle;
  logic pick_rel;

  always_comb begin
    owner_req   = owner ? req1 : req0;
    any_req     = req0 | req1;
    beat        = (state == GRANT) && owner_req && out_ready;
    burst_done  = beat && (cnt == LAST_BEAT);
    release_now = !owner_req || burst_done;
    // A lone requester wins outright; a tie goes to whoever was not served last.
    // On release the freshly updated last is the current owner.
    pick_idle   = (req0 && req1) ? ~last  : req1;
    pick_rel    = (req0 && req1) ? ~owner : req1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= GRANT;
            owner <= pick_idle;
            cnt   <= 4'd0;
          end
        end
        GRANT: begin
          if (release_now) begin
            last <= owner;
            cnt  <= 4'd0;
            if (any_req) begin
              owner <= pick_rel;
            end else begin
              state <= IDLE;
            end
          end else if (beat) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel_mux   = owner;
  assign gnt0      = (state == GRANT) && !owner;
  assign gnt1      = (state == GRANT) && owner;
  assign busy      = (state == GRANT);
  assign out_valid = (state == GRANT) && owner_req;
  assign out_data  = owner ? data1 : data0;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed vector bench for mux_share_arbiter: table of per-cycle inputs and expected outputs,
// plus a hand-written alternation sequence on a MAX_BURST=1 instance.
module tb_mux_share_arbiter;

  localparam logic [15:0] A = 16'hA5A5;
  localparam logic [15:0] B = 16'h5A5A;
  localparam logic [15:0] C = 16'h1234;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, out_ready;
  logic [15:0] data0, data1;

  logic        gnt0, gnt1, sel_mux, out_valid, busy;
  logic [15:0] out_data;
  logic        m_gnt0, m_gnt1, m_sel_mux, m_out_valid, m_busy;
  logic [15:0] m_out_data;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_share_arbiter #(.WIDTH(16), .MAX_BURST(4)) u_dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
    .sel_mux(sel_mux), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  mux_share_arbiter #(.WIDTH(16), .MAX_BURST(1)) u_mb1 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt0(m_gnt0), .gnt1(m_gnt1),
    .sel_mux(m_sel_mux), .out_data(m_out_data), .out_valid(m_out_valid),
    .out_ready(out_ready), .busy(m_busy)
  );

  typedef struct {
    logic        rst, r0, r1, rdy;
    logic [15:0] d0, d1;
    logic        g0, g1, sel, vld, bsy;
    logic [15:0] od;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic r0, input logic r1, input logic rdy,
                     input logic [15:0] d0, input logic [15:0] d1,
                     input logic g0, input logic g1, input logic sel, input logic vld,
                     input logic bsy, input logic [15:0] od);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.rdy = rdy; v.d0 = d0; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.sel = sel; v.vld = vld; v.bsy = bsy; v.od = od;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got {g0,g1,sel,vld,busy,data}=%b_%h required %b_%h",
               name, got[20:16], got[15:0], want[20:16], want[15:0]);
    end
  endtask

  initial begin
    // reset with both requesting
    add(1,1,1,1, A,B, 0,0,0,0,0, A);
    add(0,1,1,1, A,B, 0,0,0,0,0, A);
    // contention: 4 beats of requester 0, then 4 of requester 1, then back
    repeat (4) add(0,1,1,1, A,B, 1,0,0,1,1, A);
    repeat (4) add(0,1,1,1, A,B, 0,1,1,1,1, B);
    // single requester: burst-limit release re-grants owner 0 without a gap
    repeat (5) add(0,1,0,1, A,B, 1,0,0,1,1, A);
    add(0,1,1,1, A,B, 1,0,0,1,1, A);
    // early drop after 2 beats while requester 1 waits
    add(0,0,1,1, A,B, 1,0,0,0,1, A);
    // backpressure on requester 1, data held, then 4 counted beats
    repeat (5) add(0,0,1,0, A,C, 0,1,1,1,1, C);
    repeat (4) add(0,1,1,1, A,C, 0,1,1,1,1, C);
    add(0,1,0,1, A,B, 1,0,0,1,1, A);
    add(0,0,1,1, A,B, 1,0,0,0,1, A);
    repeat (2) add(0,0,1,1, A,B, 0,1,1,1,1, B);
    // early drop with nobody else waiting: IDLE, sel_mux keeps 1
    add(0,0,0,1, A,B, 0,1,1,0,1, B);
    add(0,0,0,1, A,B, 0,0,1,0,0, B);
    add(0,1,0,1, A,B, 0,0,1,0,0, B);
    add(0,1,0,1, A,B, 1,0,0,1,1, A);
    add(0,0,1,1, A,B, 1,0,0,0,1, A);
    repeat (2) add(0,0,1,1, A,B, 0,1,1,1,1, B);
    // reset during beat 3 of requester 1, then tie goes to requester 0
    add(1,1,1,1, A,B, 0,1,1,1,1, B);
    add(0,1,1,1, A,B, 0,0,0,0,0, A);
    add(0,1,1,1, A,B, 1,0,0,1,1, A);

    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1; data0 = A; data1 = B;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; req0 = tbl[i].r0; req1 = tbl[i].r1;
      out_ready = tbl[i].rdy; data0 = tbl[i].d0; data1 = tbl[i].d1;
      #1;
      check($sformatf("vec%0d", i),
            {gnt0, gnt1, sel_mux, out_valid, busy, out_data},
            {tbl[i].g0, tbl[i].g1, tbl[i].sel, tbl[i].vld, tbl[i].bsy, tbl[i].od});
    end

    // MAX_BURST=1 alternates every beat under contention; MAX_BURST=4 runs alongside
    @(negedge clk);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1; data0 = A; data1 = B;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mb1_after_reset", {m_gnt0, m_gnt1, m_sel_mux, m_out_valid, m_busy, m_out_data},
          {5'b00000, A});
    for (int k = 1; k <= 6; k++) begin
      logic e0;
      logic e4;
      @(negedge clk);
      #1;
      e0 = (k % 2) == 1;
      e4 = (k <= 4);
      check($sformatf("mb1_alt%0d", k),
            {m_gnt0, m_gnt1, m_sel_mux, m_out_valid, m_busy, m_out_data},
            {e0, ~e0, ~e0, 1'b1, 1'b1, (e0 ? A : B)});
      check($sformatf("mb4_alt%0d", k),
            {gnt0, gnt1, sel_mux, out_valid, busy, out_data},
            {e4, ~e4, ~e4, 1'b1, 1'b1, (e4 ? A : B)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/mux_share_arbiter.md
Name: mux_share_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 16-bit two-input datapath mux.
- Two requesters compete for the single downstream output; the block drives the mux select, issues grants, and forwards the selected word under a valid/ready handshake.
- Bursts are bounded so one requester cannot starve the other.
- Sits between the two producer blocks and the downstream consumer; its sel_mux output feeds the mux select.

Parameters:
WIDTH, 16, data width of each requester and of the output word
MAX_BURST, 4, maximum accepted beats per grant before forced re-arbitration (legal range 1..15)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 has a word on data0; held high while it wants service
req1  input  1  requester 1 has a word on data1
data0  input  WIDTH  requester 0 data
data1  input  WIDTH  requester 1 data
gnt0  output  1  requester 0 owns the datapath; a beat completes when gnt0 && out_ready
gnt1  output  1  requester 1 owns the datapath
sel_mux  output  1  mux select; 0 = data0, 1 = data1
out_data  output  WIDTH  selected word: data1 when sel_mux is 1, else data0 (combinational)
out_valid  output  1  out_data is valid this cycle
out_ready  input  1  downstream accepts out_data this cycle
busy  output  1  high in GRANT state

Behaviour:
- Registers: state {IDLE, GRANT}; owner (1 bit); last (1 bit, last served); cnt (4 bits, accepted beats in the current grant).
- Reset, checked before any other action: state=IDLE, owner=0, last=1, cnt=0.
- Output values under reset: gnt0=gnt1=0, sel_mux=0, out_valid=0, busy=0.
- Reset mid-burst aborts the grant; no beat is counted on the reset cycle.
- Outputs are derived from the registers:
  - sel_mux = owner. It keeps its value while in IDLE.
  - gntN = (state==GRANT) && (owner==N).
  - out_valid = (state==GRANT) && req[owner].
  - busy = (state==GRANT).
- Beat: out_valid && out_ready on a clock edge. Only beats increment cnt.
- Arbitration pick, used by IDLE and by every release:
  - If only one req is high, pick that requester.
  - If both are high, pick the requester that is not `last`. After reset, req0 wins the first tie.
- IDLE:
  - If any req is high: state=GRANT, owner=pick, cnt=0.
  - The grant is visible the cycle after req is first seen. Latency is 1 cycle.
- GRANT, release conditions:
  - (a) req[owner] is low this cycle. No beat occurs.
  - (b) A beat occurs with cnt==MAX_BURST-1.
- GRANT, on release:
  - last=owner; cnt=0.
  - If any req is high, stay in GRANT with owner=pick. The arbitration pick uses the updated `last`, so the other requester wins a tie. There is no idle bubble.
  - Otherwise go to IDLE.
- GRANT, otherwise: a beat does cnt+1; no beat holds cnt. out_ready low stalls indefinitely with no release.
- Under condition (b), if the owner is the only requester it is re-granted with cnt=0.
- The non-owner's req is ignored until release. The owner must hold data stable while out_valid && !out_ready.
- Widths: cnt compares against MAX_BURST-1 truncated to 4 bits. MAX_BURST=1 releases after every beat, which gives strict alternation under contention.

Test Plan:
- Reset: assert reset with req0=req1=1 -> gnt0=gnt1=0, out_valid=0, sel_mux=0, busy=0. Release reset; next edge -> gnt0=1, sel_mux=0.
- Single requester: req0=1 with data0=16'hA5A5 and out_ready=1 for 6 cycles -> gnt0 on cycles 1-6, out_data=16'hA5A5. At the beat-4 release, owner 0 is re-granted with no gap.
- Contention, MAX_BURST=4: req0=req1=1, out_ready=1 -> 4 beats from data0, then sel_mux=1 for 4 beats of data1, then back to 0. gnt0 and gnt1 never assert together.
- Backpressure: grant to requester 1, out_ready=0 for 5 cycles -> out_valid=1, data held, cnt stays 0. Then out_ready=1 -> beats counted, release after beat 4.
- Early drop: owner drops req after 2 beats while the other req is high -> next cycle the grant moves to the other requester. If the other req is low -> IDLE with busy=0 and sel_mux unchanged.
- Reset mid-burst: reset during beat 3 of requester 1 -> next cycle all grants are 0. After reset deasserts with both requesting, requester 0 is granted because last=1.
